// File: rtl/passcode_lock_ctrl.sv
// Passcode lock controller: BCD keypad entry, passcode programming and lockout alarm.
// Optional LOCK_AUTO_RELOCK_EN: OPEN relocks by itself after RELOCK_CYCLES idle cycles.
module passcode_lock_ctrl #(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned MAX_TRIES     = 5,
  parameter int unsigned RELOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       mode_set,
  input  logic       clear,
  input  logic       relock,
  input  logic       alarm_clr,
  output logic       unlocked,
  output logic       alarm,
  output logic [3:0] attempt_count,
  output logic [3:0] digit_count,
  output logic       pass_set
);

  localparam int unsigned NIB_W = 4;
  localparam int unsigned BUF_W = DIGITS * NIB_W;
  localparam int unsigned CNT_W = 4;

  // Elaboration-time parameter range check.
  if (DIGITS < 2 || DIGITS > 15 || MAX_TRIES < 1 || MAX_TRIES > 15 || RELOCK_CYCLES < 1)
  begin : g_bad_param
    $error("passcode_lock_ctrl: parameter out of legal range");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTER = 3'd1,
    S_PROG  = 3'd2,
    S_CHECK = 3'd3,
    S_OPEN  = 3'd4,
    S_ALARM = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [BUF_W-1:0] entry_buf, entry_buf_nxt;
  logic [BUF_W-1:0] passcode, passcode_nxt;
  logic             from_open, from_open_nxt;
  logic             check_prog, check_prog_nxt;
  logic [CNT_W-1:0] attempt_nxt;
  logic [CNT_W-1:0] digit_nxt;
  logic             pass_set_nxt;
  logic             key_ok;
  logic             last_digit;
  logic [BUF_W-1:0] buf_shifted;
  logic [CNT_W-1:0] attempt_inc;

`ifdef LOCK_AUTO_RELOCK_EN
  localparam int unsigned RC_W = $clog2(RELOCK_CYCLES + 1);
  logic [RC_W-1:0] relock_cnt, relock_cnt_nxt;
`endif

  assign key_ok      = key_valid && (key_code <= 4'd9);
  assign last_digit  = (digit_count == CNT_W'(DIGITS - 1));
  assign buf_shifted = {entry_buf[BUF_W-NIB_W-1:0], key_code};
  assign attempt_inc = attempt_count + CNT_W'(1);

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      entry_buf     <= '0;
      passcode      <= '0;
      from_open     <= 1'b0;
      check_prog    <= 1'b0;
      unlocked      <= 1'b0;
      alarm         <= 1'b0;
      attempt_count <= '0;
      digit_count   <= '0;
      pass_set      <= 1'b0;
`ifdef LOCK_AUTO_RELOCK_EN
      relock_cnt    <= '0;
`endif
    end else begin
      state         <= state_nxt;
      entry_buf     <= entry_buf_nxt;
      passcode      <= passcode_nxt;
      from_open     <= from_open_nxt;
      check_prog    <= check_prog_nxt;
      unlocked      <= (state_nxt == S_OPEN);
      alarm         <= (state_nxt == S_ALARM);
      attempt_count <= attempt_nxt;
      digit_count   <= digit_nxt;
      pass_set      <= pass_set_nxt;
`ifdef LOCK_AUTO_RELOCK_EN
      relock_cnt    <= relock_cnt_nxt;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    entry_buf_nxt  = entry_buf;
    passcode_nxt   = passcode;
    from_open_nxt  = from_open;
    check_prog_nxt = check_prog;
    attempt_nxt    = attempt_count;
    digit_nxt      = digit_count;
    pass_set_nxt   = pass_set;
`ifdef LOCK_AUTO_RELOCK_EN
    // Held at zero outside OPEN, so every entry to OPEN starts a fresh count.
    relock_cnt_nxt = '0;
`endif

    unique case (state)
      S_IDLE: begin
        if (key_ok && (pass_set ? !mode_set : mode_set)) begin
          state_nxt     = pass_set ? S_ENTER : S_PROG;
          entry_buf_nxt = buf_shifted;
          digit_nxt     = CNT_W'(1);
          from_open_nxt = 1'b0;
        end
      end

      S_ENTER, S_PROG: begin
        if (clear) begin
          state_nxt     = (state == S_PROG && from_open) ? S_OPEN : S_IDLE;
          entry_buf_nxt = '0;
          digit_nxt     = '0;
        end else if (key_ok) begin
          entry_buf_nxt = buf_shifted;
          digit_nxt     = digit_count + CNT_W'(1);
          if (last_digit) begin
            state_nxt      = S_CHECK;
            check_prog_nxt = (state == S_PROG);
          end
        end
      end

      S_CHECK: begin
        digit_nxt     = '0;
        entry_buf_nxt = '0;
        if (check_prog) begin
          passcode_nxt = entry_buf;
          pass_set_nxt = 1'b1;
          state_nxt    = S_OPEN;
        end else if (entry_buf == passcode) begin
          attempt_nxt = '0;
          state_nxt   = S_OPEN;
        end else begin
          attempt_nxt = attempt_inc;
          state_nxt   = (attempt_inc == CNT_W'(MAX_TRIES)) ? S_ALARM : S_IDLE;
        end
      end

      S_OPEN: begin
        if (relock) begin
          state_nxt = S_IDLE;
        end else if (key_ok) begin
          if (mode_set) begin
            state_nxt     = S_PROG;
            entry_buf_nxt = buf_shifted;
            digit_nxt     = CNT_W'(1);
            from_open_nxt = 1'b1;
          end
        end
`ifdef LOCK_AUTO_RELOCK_EN
        else if (relock_cnt == RC_W'(RELOCK_CYCLES - 1)) begin
          state_nxt = S_IDLE;
        end else begin
          relock_cnt_nxt = relock_cnt + RC_W'(1);
        end
`endif
      end

      S_ALARM: begin
        if (alarm_clr) begin
          state_nxt   = S_IDLE;
          attempt_nxt = '0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Self-checking bench for passcode_lock_ctrl (DIGITS=8, MAX_TRIES=5, RELOCK_CYCLES=16).
module tb_passcode_lock_ctrl;

  typedef struct packed {
    logic       unl;
    logic       alm;
    logic [3:0] att;
    logic [3:0] dig;
    logic       ps;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       mode_set;
  logic       clear;
  logic       relock;
  logic       alarm_clr;
  logic       unlocked;
  logic       alarm;
  logic [3:0] attempt_count;
  logic [3:0] digit_count;
  logic       pass_set;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  logic [3:0] good_code [8];
  logic [3:0] bad_code  [8];

  passcode_lock_ctrl #(
    .DIGITS(8),
    .MAX_TRIES(5),
    .RELOCK_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_valid(key_valid),
    .key_code(key_code),
    .mode_set(mode_set),
    .clear(clear),
    .relock(relock),
    .alarm_clr(alarm_clr),
    .unlocked(unlocked),
    .alarm(alarm),
    .attempt_count(attempt_count),
    .digit_count(digit_count),
    .pass_set(pass_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ex(input logic u, input logic a, input logic [3:0] at,
                              input logic [3:0] d, input logic p);
    exp_t e;
    e.unl = u;
    e.alm = a;
    e.att = at;
    e.dig = d;
    e.ps  = p;
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, ".unlocked"},      32'(unlocked),      32'(e.unl));
      check_eq({tag, ".alarm"},         32'(alarm),         32'(e.alm));
      check_eq({tag, ".attempt_count"}, 32'(attempt_count), 32'(e.att));
      check_eq({tag, ".digit_count"},   32'(digit_count),   32'(e.dig));
      check_eq({tag, ".pass_set"},      32'(pass_set),      32'(e.ps));
    end
  endtask

  task automatic step(input string tag, input logic kv, input logic [3:0] code,
                      input logic ms, input logic clr, input logic rl, input logic ac,
                      input exp_t e);
    @(negedge clk);
    key_valid = kv;
    key_code  = code;
    mode_set  = ms;
    clear     = clr;
    relock    = rl;
    alarm_clr = ac;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out(tag);
    key_valid = 1'b0;
    key_code  = 4'd0;
    mode_set  = 1'b0;
    clear     = 1'b0;
    relock    = 1'b0;
    alarm_clr = 1'b0;
  endtask

  // Press n digits back to back; digit_count expected to climb when dig_inc is set.
  task automatic enter_seq(input string tag, input bit bad, input logic ms, input int n,
                           input exp_t base, input bit dig_inc);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = base;
      if (dig_inc) e.dig = 4'(i + 1);
      step(tag, 1'b1, bad ? bad_code[i] : good_code[i], ms, 1'b0, 1'b0, 1'b0, e);
    end
  endtask

  initial begin
    good_code = '{4'd2, 4'd1, 4'd9, 4'd3, 4'd5, 4'd4, 4'd8, 4'd8};
    bad_code  = '{4'd2, 4'd1, 4'd9, 4'd3, 4'd5, 4'd4, 4'd8, 4'd7};
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'd0;
    mode_set  = 1'b0;
    clear     = 1'b0;
    relock    = 1'b0;
    alarm_clr = 1'b0;

    sb_q.push_back(ex(0, 0, 0, 0, 0));
    #2;
    compare_out("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Program from reset, then relock with a simultaneous key.
    enter_seq("prog", 0, 1'b1, 8, ex(0, 0, 0, 0, 0), 1);
    step("prog_done", 0, 4'd0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1));
    step("relock_key", 1, 4'd4, 1, 0, 1, 0, ex(0, 0, 0, 0, 1));

    enter_seq("unlock", 0, 1'b0, 8, ex(0, 0, 0, 0, 1), 1);
    step("unlock_done", 0, 4'd0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1));
    step("relock", 0, 4'd0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1));

    // Five wrong entries escalate to ALARM.
    for (int k = 1; k <= 5; k++) begin
      enter_seq("bad", 1, 1'b0, 8, ex(0, 0, 4'(k - 1), 0, 1), 1);
      step("bad_done", 0, 4'd0, 0, 0, 0, 0,
           (k < 5) ? ex(0, 0, 4'(k), 0, 1) : ex(0, 1, 4'd5, 0, 1));
    end
    enter_seq("alarm_keys", 0, 1'b0, 8, ex(0, 1, 5, 0, 1), 0);
    step("alarm_clr_rl", 0, 4'd0, 0, 1, 1, 0, ex(0, 1, 5, 0, 1));
    step("alarm_clr", 0, 4'd0, 0, 0, 0, 1, ex(0, 0, 0, 0, 1));
    step("alarm_clr_idle", 0, 4'd0, 0, 0, 0, 1, ex(0, 0, 0, 0, 1));

    // One miss, then an aborted partial entry keeps the attempt count.
    enter_seq("miss", 1, 1'b0, 8, ex(0, 0, 0, 0, 1), 1);
    step("miss_done", 0, 4'd0, 0, 0, 0, 0, ex(0, 0, 1, 0, 1));
    enter_seq("partial", 0, 1'b0, 3, ex(0, 0, 1, 0, 1), 1);
    step("code12_enter", 1, 4'd12, 0, 0, 0, 0, ex(0, 0, 1, 3, 1));
    step("clear_key", 1, 4'd5, 0, 1, 0, 0, ex(0, 0, 1, 0, 1));
    step("code12_idle", 1, 4'd12, 0, 0, 0, 0, ex(0, 0, 1, 0, 1));

    // Unlock, then abort a programming entry started from OPEN.
    enter_seq("unlock2", 0, 1'b0, 8, ex(0, 0, 1, 0, 1), 1);
    step("unlock2_done", 0, 4'd0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1));
    step("open_ms0_key", 1, 4'd3, 0, 0, 0, 0, ex(1, 0, 0, 0, 1));
    step("prog_from_open", 1, 4'd6, 1, 0, 0, 0, ex(0, 0, 0, 1, 1));
    step("prog_clear", 0, 4'd0, 0, 1, 0, 0, ex(1, 0, 0, 0, 1));

    for (int i = 0; i < 20; i++) begin
`ifdef LOCK_AUTO_RELOCK_EN
      step("open_idle", 0, 4'd0, 0, 0, 0, 0, ex((i < 15), 0, 0, 0, 1));
`else
      step("open_idle", 0, 4'd0, 0, 0, 0, 0, ex(1, 0, 0, 0, 1));
`endif
    end
    step("relock2", 0, 4'd0, 0, 0, 1, 0, ex(0, 0, 0, 0, 1));

    // Asynchronous reset in the middle of an entry.
    enter_seq("pre_reset", 0, 1'b0, 5, ex(0, 0, 0, 0, 1), 1);
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.push_back(ex(0, 0, 0, 0, 0));
    #1;
    compare_out("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_ms0", 1, 4'd2, 0, 0, 0, 0, ex(0, 0, 0, 0, 0));
    step("post_rst_ms1", 1, 4'd2, 1, 0, 0, 0, ex(0, 0, 0, 1, 0));

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
